// File: rtl/game_pkg.sv
`default_nettype none
// =============================================================================
// Module      : game_pkg
// Description : Shared scheduler state encoding and colour width.
// Revision    : 1.0 - initial release
// =============================================================================
package game_pkg;

   localparam int COLOUR_W = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERASE  = 3'd1,
      S_UPDATE = 3'd2,
      S_LATCH  = 3'd3,
      S_DRAW   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// =============================================================================
// Module      : tick_divider
// Description : Free-running divider; one-cycle tick every CLK_DIV clocks.
// Revision    : 1.0 - initial release
// =============================================================================
module tick_divider #(
   parameter int CLK_DIV = 833334
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q + 1'b1;
      if (count_q == CNT_LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : frame_scheduler
// Description : Per-frame erase / update / redraw sequencer for one sprite box.
// Revision    : 1.0 - initial release
// =============================================================================
module frame_scheduler
   import game_pkg::*;
#(
   parameter int                  CLK_DIV      = 833334,
   parameter int                  SPR_W        = 4,
   parameter int                  SPR_H        = 4,
   parameter int                  X_W          = 8,
   parameter int                  Y_W          = 7,
   parameter logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                draw,
   input  logic                setoff,
   input  logic [X_W-1:0]      obj_x,
   input  logic [Y_W-1:0]      obj_y,
   input  logic [COLOUR_W-1:0] obj_colour,
   output logic [X_W-1:0]      plot_x,
   output logic [Y_W-1:0]      plot_y,
   output logic [COLOUR_W-1:0] plot_colour,
   output logic                plot_we,
   output logic                update_pulse,
   output logic                frame_tick,
   output logic                busy,
   output logic                overrun
);

   localparam int DX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int DY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam logic [DX_W-1:0] DX_LAST = DX_W'(SPR_W - 1);
   localparam logic [DY_W-1:0] DY_LAST = DY_W'(SPR_H - 1);

   state_t              state_q, state_d;
   logic [DX_W-1:0]     dx_q, dx_d;
   logic [DY_W-1:0]     dy_q, dy_d;
   logic [X_W-1:0]      old_x_q, old_x_d;
   logic [Y_W-1:0]      old_y_q, old_y_d;
   logic [COLOUR_W-1:0] col_q, col_d;
   logic                old_valid_q, old_valid_d;
   logic                overrun_q, overrun_d;

   logic                w_tick;
   logic                w_walk;
   logic                w_last;

   tick_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_divider (
      .clock (clock),
      .reset (reset),
      .tick  (w_tick)
   );

   assign w_walk = (state_q == S_ERASE) || (state_q == S_DRAW);
   assign w_last = (dx_q == DX_LAST) && (dy_q == DY_LAST);

   always_comb begin
      state_d     = state_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      old_x_d     = old_x_q;
      old_y_d     = old_y_q;
      col_d       = col_q;
      old_valid_d = old_valid_q;
      overrun_d   = overrun_q;

      // A tick landing mid-sequence is dropped, only flagged.
      if (w_tick && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      // Raster walk wraps to (0,0) on the last pixel, ready for the next pass.
      if (w_walk) begin
         if (dx_q == DX_LAST) begin
            dx_d = '0;
            dy_d = (dy_q == DY_LAST) ? '0 : dy_q + 1'b1;
         end else begin
            dx_d = dx_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (w_tick && draw) begin
               state_d = old_valid_q ? S_ERASE : S_LATCH;
            end
         end
         S_ERASE: begin
            if (w_last) begin
               state_d = setoff ? S_UPDATE : S_LATCH;
            end
         end
         S_UPDATE: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            old_x_d     = obj_x;
            old_y_d     = obj_y;
            col_d       = obj_colour;
            old_valid_d = 1'b1;
            state_d     = S_DRAW;
         end
         S_DRAW: begin
            if (w_last) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dx_q        <= '0;
         dy_q        <= '0;
         old_x_q     <= '0;
         old_y_q     <= '0;
         col_q       <= '0;
         old_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         old_x_q     <= old_x_d;
         old_y_q     <= old_y_d;
         col_q       <= col_d;
         old_valid_q <= old_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign plot_we      = w_walk;
   assign plot_x       = w_walk ? (old_x_q + X_W'(dx_q)) : '0;
   assign plot_y       = w_walk ? (old_y_q + Y_W'(dy_q)) : '0;
   assign plot_colour  = (state_q == S_ERASE) ? ERASE_COLOUR :
                         (state_q == S_DRAW)  ? col_q        : '0;
   assign update_pulse = (state_q == S_UPDATE);
   assign busy         = (state_q != S_IDLE);
   assign overrun      = overrun_q;
   assign frame_tick   = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : tb_frame_scheduler
// Description : Frame table plus scoreboard bench for frame_scheduler.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_frame_scheduler;

   localparam int DIV_A = 40;
   localparam int DIV_B = 20;

   typedef struct {
      logic       draw;
      logic       setoff;
      logic       drop;
      logic [7:0] ox;
      logic [6:0] oy;
      logic [2:0] col;
      logic [7:0] nx;
      logic [6:0] ny;
      int         exp_busy;
      int         exp_upd;
   } frame_t;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset, draw, setoff;
   logic [7:0] obj_x;
   logic [6:0] obj_y;
   logic [2:0] obj_colour;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_colour;
   logic       plot_we, update_pulse, frame_tick, busy, overrun;

   logic       b_reset, b_draw, b_setoff;
   logic [7:0] b_obj_x;
   logic [6:0] b_obj_y;
   logic [2:0] b_obj_colour;
   logic [7:0] b_plot_x;
   logic [6:0] b_plot_y;
   logic [2:0] b_plot_colour;
   logic       b_plot_we, b_update_pulse, b_frame_tick, b_busy, b_overrun;

   frame_scheduler #(.CLK_DIV(DIV_A), .SPR_W(4), .SPR_H(4), .X_W(8), .Y_W(7),
                     .ERASE_COLOUR(3'b000)) u_dut (
      .clock(clock), .reset(reset), .draw(draw), .setoff(setoff),
      .obj_x(obj_x), .obj_y(obj_y), .obj_colour(obj_colour),
      .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
      .plot_we(plot_we), .update_pulse(update_pulse), .frame_tick(frame_tick),
      .busy(busy), .overrun(overrun)
   );

   frame_scheduler #(.CLK_DIV(DIV_B), .SPR_W(4), .SPR_H(4), .X_W(8), .Y_W(7),
                     .ERASE_COLOUR(3'b000)) u_dut_fast (
      .clock(clock), .reset(b_reset), .draw(b_draw), .setoff(b_setoff),
      .obj_x(b_obj_x), .obj_y(b_obj_y), .obj_colour(b_obj_colour),
      .plot_x(b_plot_x), .plot_y(b_plot_y), .plot_colour(b_plot_colour),
      .plot_we(b_plot_we), .update_pulse(b_update_pulse), .frame_tick(b_frame_tick),
      .busy(b_busy), .overrun(b_overrun)
   );

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_tick = -1;
   pix_t       sb[$];
   frame_t     tbl[8];
   logic [7:0] m_x;
   logic [6:0] m_y;
   logic       m_valid;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_tick_a();
      int n = 0;
      @(negedge clock);
      while (!frame_tick && n < 2 * DIV_A + 4) begin
         @(negedge clock);
         n++;
      end
      if (!frame_tick) check("tick_seen", frame_tick, 1);
      else if (last_tick >= 0) check("tick_period", cyc - last_tick, DIV_A);
      last_tick = cyc;
   endtask

   task automatic wait_tick_b();
      int n = 0;
      @(negedge clock);
      while (!b_frame_tick && n < 2 * DIV_B + 4) begin
         @(negedge clock);
         n++;
      end
      if (!b_frame_tick) check("b_tick_seen", b_frame_tick, 1);
   endtask

   task automatic push_box(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      pix_t p;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            p.x = 8'(x + 8'(i));
            p.y = 7'(y + 7'(j));
            p.c = c;
            sb.push_back(p);
         end
      end
   endtask

   task automatic run_frame(input frame_t f);
      int   nbusy = 0;
      int   nupd = 0;
      pix_t e;
      draw = f.draw; setoff = f.setoff;
      obj_x = f.ox; obj_y = f.oy; obj_colour = f.col;
      wait_tick_a();
      if (f.draw) begin
         if (m_valid) push_box(m_x, m_y, 3'b000);
         if (f.setoff && !f.drop) begin m_x = f.nx; m_y = f.ny; end
         else begin m_x = f.ox; m_y = f.oy; end
         push_box(m_x, m_y, f.col);
         m_valid = 1'b1;
      end
      for (int i = 0; i < DIV_A - 2; i++) begin
         @(negedge clock);
         if (i == 0 && f.drop) begin draw = 1'b0; setoff = 1'b0; end
         if (busy) nbusy++;
         if (update_pulse) begin nupd++; obj_x = f.nx; obj_y = f.ny; end
         if (plot_we) begin
            if (sb.size() == 0) check("unexpected_write", plot_we, 0);
            else begin
               e = sb.pop_front();
               check("pixel_xyc", {plot_x, plot_y, plot_colour}, {e.x, e.y, e.c});
            end
         end
      end
      check("busy_cycles", nbusy, f.exp_busy);
      check("update_pulses", nupd, f.exp_upd);
      check("missing_writes", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int nb, nw;
      //         draw  setoff drop  ox      oy      col     nx      ny      busy upd
      tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd10,  7'd20,  3'b100, 8'd10,  7'd20,  17,  0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd10,  7'd20,  3'b100, 8'd11,  7'd20,  34,  1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 8'd11,  7'd20,  3'b010, 8'd254, 7'd126, 34,  1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd254, 7'd126, 3'b011, 8'd254, 7'd126, 33,  0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd254, 7'd126, 3'b011, 8'd254, 7'd126, 0,   0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 8'd254, 7'd126, 3'b011, 8'd1,   7'd1,   0,   0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 8'd254, 7'd126, 3'b011, 8'd254, 7'd126, 0,   0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 8'd50,  7'd60,  3'b111, 8'd99,  7'd99,  33,  0};

      reset = 1'b1; draw = 1'b0; setoff = 1'b0;
      obj_x = '0; obj_y = '0; obj_colour = '0;
      b_reset = 1'b1; b_draw = 1'b0; b_setoff = 1'b0;
      b_obj_x = '0; b_obj_y = '0; b_obj_colour = '0;
      m_x = '0; m_y = '0; m_valid = 1'b0;

      repeat (3) @(negedge clock);
      check("reset_outputs",
            {plot_we, update_pulse, busy, overrun, frame_tick, plot_x, plot_y, plot_colour}, 0);
      reset = 1'b0;

      for (int k = 0; k < 8; k++) run_frame(tbl[k]);
      check("no_overrun_a", overrun, 0);

      // Reset landing on the fifth erase pixel
      draw = 1'b1; setoff = 1'b0; obj_x = 8'd70; obj_y = 7'd80; obj_colour = 3'b001;
      wait_tick_a();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("erase_we_colour", {plot_we, plot_colour}, {1'b1, 3'b000});
      end
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_outputs",
            {plot_we, update_pulse, busy, overrun, frame_tick, plot_x, plot_y, plot_colour}, 0);
      reset = 1'b0;
      m_valid = 1'b0;
      last_tick = -1;
      run_frame('{1'b1, 1'b0, 1'b0, 8'd70, 7'd80, 3'b001, 8'd70, 7'd80, 17, 0});

      // Short divider: tick during redraw must be dropped and flagged
      b_draw = 1'b1; b_setoff = 1'b1; b_obj_x = 8'd5; b_obj_y = 7'd5; b_obj_colour = 3'b001;
      @(negedge clock);
      b_reset = 1'b0;
      wait_tick_b();
      wait_tick_b();
      check("b_overrun_before", b_overrun, 0);
      nb = 0; nw = 0;
      for (int i = 1; i <= DIV_B * 2; i++) begin
         @(negedge clock);
         if (b_busy) nb++;
         if (b_plot_we) nw++;
      end
      check("b_busy_cycles", nb, 34);
      check("b_writes", nw, 32);
      check("b_overrun_sticky", b_overrun, 1);
      check("b_late_tick", b_frame_tick, 1);
      @(negedge clock);
      check("b_restart_erase", {b_busy, b_plot_we, b_plot_colour}, {1'b1, 1'b1, 3'b000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences the per-frame VGA writes for the player object: erase the old sprite box, pulse the datapath to advance position, then redraw at the new position.
- Sits between the game control FSM (draw/setoff enables) and the datapath/VGA adapter; sole owner of the framebuffer write port for the object.
- Contains a free-running frame-tick divider, so object motion rate is independent of the system clock.

Parameters:
- CLK_DIV, 833334, clock cycles per frame tick (60 Hz at 50 MHz); minimum 2*SPR_W*SPR_H+4
- SPR_W, 4, sprite box width in pixels
- SPR_H, 4, sprite box height in pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ERASE_COLOUR, 3'b000, background colour written during erase

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- draw  in  1  control FSM permits plotting this frame
- setoff  in  1  control FSM permits movement (update) this frame
- obj_x  in  X_W  current object x from datapath (top-left)
- obj_y  in  Y_W  current object y from datapath
- obj_colour  in  3  object colour
- plot_x  out  X_W  framebuffer write x
- plot_y  out  Y_W  framebuffer write y
- plot_colour  out  3  framebuffer write colour
- plot_we  out  1  framebuffer write enable, one pixel per cycle
- update_pulse  out  1  one-cycle strobe: datapath advances obj_x/obj_y
- frame_tick  out  1  one-cycle strobe every CLK_DIV cycles
- busy  out  1  high in any state other than S_IDLE
- overrun  out  1  sticky: a frame_tick arrived while busy

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high. On reset all outputs are 0. State=S_IDLE; divider=0; dx=dy=0; old_x=old_y=0; old_valid=0; overrun=0.
- Divider: counts 0..CLK_DIV-1 and wraps; frame_tick=1 exactly when count==CLK_DIV-1. It free-runs irrespective of draw and busy.
- S_IDLE: leaves only on frame_tick && draw.
  - To S_ERASE if old_valid, else to S_LATCH.
  - Tick with draw=0: stays in S_IDLE, no writes.
- S_ERASE: plot_we=1, plot_x=old_x+dx, plot_y=old_y+dy, plot_colour=ERASE_COLOUR.
  - Raster order: dx increments fastest 0..SPR_W-1, then dy 0..SPR_H-1.
  - Lasts exactly SPR_W*SPR_H cycles.
  - Then goes to S_UPDATE if setoff (sampled on the last erase cycle), else S_LATCH.
- S_UPDATE: one cycle, update_pulse=1, plot_we=0; then S_LATCH.
- S_LATCH: one cycle, plot_we=0; old_x<=obj_x, old_y<=obj_y, col<=obj_colour, old_valid<=1; then S_DRAW.
- S_DRAW: same raster walk at old_x/old_y (now the new position) with col; SPR_W*SPR_H cycles; then S_IDLE.
- Outputs are decoded from registered state, dx, dy and the latched base: tick at cycle T gives first plot_we at T+1.
- Full frame with setoff=1 keeps busy high for 2*W*H+2 cycles.
- Coordinate addition is modulo 2^X_W / 2^Y_W (wraps, no clamp); the datapath guarantees in-range positions.
- draw or setoff falling mid-sequence does not abort; the sequence completes. setoff is sampled only at the end of S_ERASE.
- frame_tick while busy: the tick is dropped and overrun<=1 (sticky until reset).
- Reset mid-sequence: plot_we drops the next cycle and old_valid=0, so the next frame draws without erasing.
- Counters dx, dy are sized clog2(SPR_W) and clog2(SPR_H), minimum 1 bit.

Decomposition:
- Shared package game_pkg: state encoding constants (S_IDLE, S_ERASE, S_UPDATE, S_LATCH, S_DRAW) and the colour width constant COLOUR_W=3.
- One natural sub-module, tick_divider (parameter CLK_DIV; ports clock, reset, tick), reusable for other timed game elements.
- The raster walker stays inline.

Test Plan (CLK_DIV=40, SPR_W=SPR_H=4):
- Reset, draw=1, setoff=0, obj=(10,20), col=3'b100 -> first tick: no erase; 1 latch cycle, then 16 writes covering x 10..13 and y 20..23 in raster order, colour 100; busy for 17 cycles.
- Second tick, setoff=1, datapath moves obj to (11,20) on update_pulse -> 16 erase writes colour 000 at (10..13, 20..23); update_pulse high for exactly 1 cycle; 16 draws at (11..14, 20..23); busy 34 cycles.
- obj=(254,126) -> plot_x sequence 254,255,0,1 and plot_y 126,127,0,1 (wrap).
- draw=0 over 3 ticks -> plot_we, update_pulse and busy never assert; frame_tick still pulses every 40 cycles.
- Bench forces CLK_DIV=20 (less than 34) with setoff=1 -> tick during S_DRAW sets overrun=1; the next sequence starts only on a later tick.
- Reset asserted at the 5th erase cycle -> all outputs 0 the next cycle; the next frame skips erase (old_valid=0).
